float_add_pipe: RTL and testbench

- Parametrised, fully pipelined floating-point adder/subtractor. It succeeds the fixed fp16 adder in the convolution datapath.
- Adds the following over that adder: configurable exponent and fraction widths, a runtime subtract mode, IEEE round-to-nearest-even, inf/NaN handling, and selectable overflow saturation.
- Sits between the multiplier array and the accumulator tree. Accepts one operand pair per clock and produces one result per clock.

---
 rtl/float_add_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_float_add_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_pipe.sv
// Five-stage pipelined floating-point adder/subtractor with RNE rounding,
// inf/NaN handling, subnormal flush-to-zero and optional overflow saturation.
module float_add_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    de_in,
    input  logic                    op_sub,
    input  logic [EXP_W+FRAC_W:0]   data_in_01,
    input  logic [EXP_W+FRAC_W:0]   data_in_02,
    output logic                    de_out,
    output logic [EXP_W+FRAC_W:0]   data_out
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int M    = FRAC_W + 4;          // hidden + frac + G/R/S
    localparam int EW2  = EXP_W + 2;
    localparam int SW   = $clog2(M + 1);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(EMAX);

    function automatic logic [SW-1:0] lzc(input logic [M-1:0] v);
        lzc = SW'(M);
        for (int unsigned i = 0; i < M; i++)
            if (v[i]) lzc = SW'(M - 1 - i);
    endfunction

    // ---------------- stage 1: capture and classify ----------------
    logic [EXP_W-1:0]  in_ea, in_eb;
    logic [FRAC_W-1:0] in_fa, in_fb;
    assign in_ea = data_in_01[W-2:FRAC_W];
    assign in_eb = data_in_02[W-2:FRAC_W];
    assign in_fa = data_in_01[FRAC_W-1:0];
    assign in_fb = data_in_02[FRAC_W-1:0];

    logic              v1, s1_sa, s1_sb, s1_za, s1_zb, s1_ia, s1_ib, s1_na, s1_nb;
    logic [EXP_W-1:0]  s1_ea, s1_eb;
    logic [FRAC_W-1:0] s1_fa, s1_fb;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v1 <= 1'b0;
            s1_sa <= 1'b0; s1_sb <= 1'b0;
            s1_ea <= '0;   s1_eb <= '0;
            s1_fa <= '0;   s1_fb <= '0;
            s1_za <= 1'b0; s1_zb <= 1'b0;
            s1_ia <= 1'b0; s1_ib <= 1'b0;
            s1_na <= 1'b0; s1_nb <= 1'b0;
        end else begin
            v1 <= de_in;
            if (de_in) begin
                s1_sa <= data_in_01[W-1];
                s1_sb <= data_in_02[W-1] ^ op_sub;
                s1_ea <= in_ea;
                s1_eb <= in_eb;
                s1_fa <= in_fa;
                s1_fb <= in_fb;
                s1_za <= (in_ea == '0);
                s1_zb <= (in_eb == '0);
                s1_ia <= (in_ea == '1) && (in_fa == '0);
                s1_ib <= (in_eb == '1) && (in_fb == '0);
                s1_na <= (in_ea == '1) && (in_fa != '0);
                s1_nb <= (in_eb == '1) && (in_fb != '0);
            end
        end
    end

    // ---------------- stage 2: swap and align ----------------
    logic [EXP_W+FRAC_W-1:0] mag_a, mag_b;
    logic                    a_ge, l_s, l_z, sm_z;
    logic [EXP_W-1:0]        l_e, sm_e, shamt;
    logic [FRAC_W-1:0]       l_f, sm_f;
    logic [M-1:0]            ml, ms_raw, ms_al;
    logic [2*M-1:0]          wide;

    always_comb begin
        mag_a = s1_za ? '0 : {s1_ea, s1_fa};
        mag_b = s1_zb ? '0 : {s1_eb, s1_fb};
        a_ge  = (mag_a >= mag_b);
        if (a_ge) begin
            l_s = s1_sa; l_e = s1_ea; l_f = s1_fa; l_z = s1_za;
            sm_e = s1_eb; sm_f = s1_fb; sm_z = s1_zb;
        end else begin
            l_s = s1_sb; l_e = s1_eb; l_f = s1_fb; l_z = s1_zb;
            sm_e = s1_ea; sm_f = s1_fa; sm_z = s1_za;
        end
        ml     = l_z  ? '0 : {1'b1, l_f, 3'b000};
        ms_raw = sm_z ? '0 : {1'b1, sm_f, 3'b000};
        // a zero small operand has exp 0, so shamt never wraps negative
        shamt  = l_e - sm_e;
        wide   = {ms_raw, {M{1'b0}}} >> shamt;
        if (int'(shamt) >= FRAC_W + 3)
            ms_al = {{(M-1){1'b0}}, |ms_raw};
        else
            ms_al = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};
    end

    logic             v2, s2_s, s2_sub, s2_nan, s2_inf, s2_infs, s2_nz;
    logic [EXP_W-1:0] s2_e;
    logic [M-1:0]     s2_ml, s2_ms;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v2 <= 1'b0;
            s2_s <= 1'b0; s2_sub <= 1'b0; s2_e <= '0;
            s2_ml <= '0;  s2_ms <= '0;
            s2_nan <= 1'b0; s2_inf <= 1'b0; s2_infs <= 1'b0; s2_nz <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_s    <= l_s;
                s2_sub  <= s1_sa ^ s1_sb;
                s2_e    <= l_e;
                s2_ml   <= ml;
                s2_ms   <= ms_al;
                s2_nan  <= s1_na | s1_nb | (s1_ia & s1_ib & (s1_sa ^ s1_sb));
                s2_inf  <= s1_ia | s1_ib;
                s2_infs <= s1_ia ? s1_sa : s1_sb;
                s2_nz   <= s1_za & s1_zb & s1_sa & s1_sb;
            end
        end
    end

    // ---------------- stage 3: add / subtract ----------------
    logic             v3, s3_s, s3_nan, s3_inf, s3_infs, s3_nz;
    logic [EXP_W-1:0] s3_e;
    logic [M:0]       s3_sum;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v3 <= 1'b0;
            s3_s <= 1'b0; s3_e <= '0; s3_sum <= '0;
            s3_nan <= 1'b0; s3_inf <= 1'b0; s3_infs <= 1'b0; s3_nz <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                s3_sum  <= s2_sub ? ({1'b0, s2_ml} - {1'b0, s2_ms})
                                  : ({1'b0, s2_ml} + {1'b0, s2_ms});
                s3_s    <= s2_s;
                s3_e    <= s2_e;
                s3_nan  <= s2_nan;
                s3_inf  <= s2_inf;
                s3_infs <= s2_infs;
                s3_nz   <= s2_nz;
            end
        end
    end

    // ---------------- stage 4: normalise ----------------
    logic [SW-1:0]           lz;
    logic signed [EW2-1:0]   e_in, n_e;
    logic [M-1:0]            n_m;
    logic                    n_zero;

    always_comb begin
        lz     = lzc(s3_sum[M-1:0]);
        e_in   = $signed({2'b00, s3_e});
        n_zero = (s3_sum == '0);
        if (s3_sum[M]) begin
            n_m = {s3_sum[M:2], s3_sum[1] | s3_sum[0]};
            n_e = e_in + EW2'(1);
        end else begin
            n_m = s3_sum[M-1:0] << lz;
            n_e = e_in - $signed(EW2'(lz));
        end
    end

    logic                  v4, s4_s, s4_zero, s4_nan, s4_inf, s4_infs;
    logic [M-1:0]          s4_m;
    logic signed [EW2-1:0] s4_e;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v4 <= 1'b0;
            s4_s <= 1'b0; s4_zero <= 1'b0; s4_m <= '0; s4_e <= '0;
            s4_nan <= 1'b0; s4_inf <= 1'b0; s4_infs <= 1'b0;
        end else begin
            v4 <= v3;
            if (v3) begin
                s4_m    <= n_m;
                s4_e    <= n_e;
                s4_zero <= n_zero;
                s4_s    <= n_zero ? s3_nz : s3_s;
                s4_nan  <= s3_nan;
                s4_inf  <= s3_inf;
                s4_infs <= s3_infs;
            end
        end
    end

    // ---------------- stage 5: round and pack ----------------
    logic                  rnd_inc;
    logic [FRAC_W+1:0]     rnd;
    logic signed [EW2-1:0] f_e;
    logic [FRAC_W-1:0]     f_frac;
    logic [W-1:0]          res;

    always_comb begin
        rnd_inc = s4_m[2] & (s4_m[1] | s4_m[0] | s4_m[3]);
        rnd     = {1'b0, s4_m[M-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_inc};
        if (rnd[FRAC_W+1]) begin
            f_e    = s4_e + EW2'(1);
            f_frac = '0;
        end else begin
            f_e    = s4_e;
            f_frac = rnd[FRAC_W-1:0];
        end
        if (s4_nan)
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        else if (s4_inf)
            res = {s4_infs, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (s4_zero)
            res = {s4_s, {(W-1){1'b0}}};
        else if (!f_e[EW2-1] && (f_e >= EMAX_S))
            res = (SAT != 0) ? {s4_s, EXP_W'(EMAX - 1), {FRAC_W{1'b1}}}
                             : {s4_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (f_e[EW2-1] || (f_e == '0))
            res = {s4_s, {(W-1){1'b0}}};
        else
            res = {s4_s, f_e[EXP_W-1:0], f_frac};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            de_out   <= 1'b0;
            data_out <= '0;
        end else begin
            de_out <= v4;
            if (v4) data_out <= res;
        end
    end

endmodule

// File: tb/tb_float_add_pipe.sv
// Bench for float_add_pipe: fp16 (SAT=0/1) and bf16 builds driven together,
// checked against a real-arithmetic reference through per-build scoreboards.
module tb_float_add_pipe;

    logic        clk = 1'b0;
    logic        rst_b, de_in, op_sub;
    logic [15:0] a, b, bfa, bfb;
    logic        de0, de1, de2;
    logic [15:0] q0, q1, q2;

    always #5 clk = ~clk;

    float_add_pipe #(.EXP_W(5), .FRAC_W(10), .SAT(0)) u_fp (
        .clk(clk), .rst_b(rst_b), .de_in(de_in), .op_sub(op_sub),
        .data_in_01(a), .data_in_02(b), .de_out(de0), .data_out(q0));
    float_add_pipe #(.EXP_W(5), .FRAC_W(10), .SAT(1)) u_sat (
        .clk(clk), .rst_b(rst_b), .de_in(de_in), .op_sub(op_sub),
        .data_in_01(a), .data_in_02(b), .de_out(de1), .data_out(q1));
    float_add_pipe #(.EXP_W(8), .FRAC_W(7), .SAT(0)) u_bf (
        .clk(clk), .rst_b(rst_b), .de_in(de_in), .op_sub(op_sub),
        .data_in_01(bfa), .data_in_02(bfb), .de_out(de2), .data_out(q2));

    typedef struct { logic [15:0] val; int cyc; } exp_t;
    typedef struct {
        logic [15:0] a, b; logic sub; logic [15:0] e0, e1, bfa, bfb, ebf;
    } vec_t;

    exp_t q_fp[$], q_sat[$], q_bf[$];
    exp_t e;
    vec_t tbl[18];
    int   checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc++;

    function automatic real p2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic sub, input int ew, input int fw,
                                            input bit sat);
        int emax, bias, fmask, qnan, ex, ey, fx, fy, ex2, ip, be, sgn;
        bit sx, sy, nx, ny, ix, iy;
        real vx, vy, r, mag, scaled, rem;
        emax  = (1 << ew) - 1;
        bias  = (1 << (ew - 1)) - 1;
        fmask = (1 << fw) - 1;
        qnan  = (emax << fw) | (1 << (fw - 1));
        ex = (int'(x) >> fw) & emax;  fx = int'(x) & fmask;  sx = x[15];
        ey = (int'(y) >> fw) & emax;  fy = int'(y) & fmask;  sy = y[15] ^ sub;
        nx = (ex == emax) && (fx != 0);  ix = (ex == emax) && (fx == 0);
        ny = (ey == emax) && (fy != 0);  iy = (ey == emax) && (fy == 0);
        if (nx || ny) return 16'(qnan);
        if (ix && iy) return (sx != sy) ? 16'(qnan) : 16'((int'(sx) << 15) | (emax << fw));
        if (ix) return 16'((int'(sx) << 15) | (emax << fw));
        if (iy) return 16'((int'(sy) << 15) | (emax << fw));
        vx = (ex == 0) ? 0.0 : (1.0 + real'(fx) / p2(fw)) * p2(ex - bias);
        vy = (ey == 0) ? 0.0 : (1.0 + real'(fy) / p2(fw)) * p2(ey - bias);
        if (sx) vx = -vx;
        if (sy) vy = -vy;
        r = vx + vy;
        if (r == 0.0) return (ex == 0 && ey == 0 && sx && sy) ? 16'h8000 : 16'h0000;
        sgn = (r < 0.0) ? 1 : 0;
        mag = (r < 0.0) ? -r : r;
        ex2 = 0;
        while (mag >= 2.0) begin mag = mag / 2.0; ex2++; end
        while (mag < 1.0) begin mag = mag * 2.0; ex2--; end
        scaled = mag * p2(fw);
        ip  = $rtoi(scaled);
        rem = scaled - real'(ip);
        if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == (2 << fw)) begin ip = 1 << fw; ex2++; end
        be = ex2 + bias;
        if (be >= emax)
            return sat ? 16'((sgn << 15) | ((emax - 1) << fw) | fmask)
                       : 16'((sgn << 15) | (emax << fw));
        if (be <= 0) return 16'(sgn << 15);
        return 16'((sgn << 15) | (be << fw) | (ip - (1 << fw)));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] act, input exp_t ex);
        checks++;
        if (act !== ex.val || (cyc - ex.cyc) != 5) begin
            errors++;
            $display("FAIL %s: got %h after %0d cycles, expected %h after 5 cycles",
                     name, act, cyc - ex.cyc, ex.val);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected de_out with data %h, expected no result", name, act);
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (de0) begin
                if (q_fp.size() == 0) unexpected("fp16", q0);
                else begin e = q_fp.pop_front(); chk_out("fp16", q0, e); end
            end
            if (de1) begin
                if (q_sat.size() == 0) unexpected("fp16_sat", q1);
                else begin e = q_sat.pop_front(); chk_out("fp16_sat", q1, e); end
            end
            if (de2) begin
                if (q_bf.size() == 0) unexpected("bf16", q2);
                else begin e = q_bf.pop_front(); chk_out("bf16", q2, e); end
            end
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic sub,
                         input logic [15:0] ibfa, input logic [15:0] ibfb,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        @(negedge clk);
        de_in = 1'b1; op_sub = sub; a = ia; b = ib; bfa = ibfa; bfb = ibfb;
        q_fp.push_back('{e0, cyc});
        q_sat.push_back('{e1, cyc});
        q_bf.push_back('{e2, cyc});
    endtask

    task automatic rand_issue();
        logic [15:0] ra, rb, rc, rd;
        logic        rs;
        ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom);
        rs = 1'($urandom);
        issue(ra, rb, rs, rc, rd, ref_add(ra, rb, rs, 5, 10, 1'b0),
              ref_add(ra, rb, rs, 5, 10, 1'b1), ref_add(rc, rd, rs, 8, 7, 1'b0));
    endtask

    task automatic idle();
        @(negedge clk);
        de_in = 1'b0; op_sub = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom); bfa = 16'($urandom); bfb = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while ((q_fp.size() + q_sat.size() + q_bf.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q_fp.size() + q_sat.size() + q_bf.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0",
                     q_fp.size() + q_sat.size() + q_bf.size());
        end
    endtask

    initial begin
        int n;
        tbl[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 16'h4000, 16'h3F80, 16'h3F80, 16'h4000};
        tbl[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 16'h0000, 16'h3F80, 16'h3F80, 16'h0000};
        tbl[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h8000, 16'h7F7F, 16'h7F7F, 16'h7F80};
        tbl[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 16'h3C00, 16'h8000, 16'h8000, 16'h8000};
        tbl[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 16'h3C02, 16'h7F80, 16'hFF80, 16'h7FC0};
        tbl[5]  = '{16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 16'h3C00, 16'h7F80, 16'h3F80, 16'h7F80};
        tbl[6]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 16'h7BFF, 16'h3F80, 16'h0000, 16'h3F80};
        tbl[7]  = '{16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00, 16'hFBFF, 16'h0001, 16'h3F80, 16'h3F80};
        tbl[8]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 16'h7E00, 16'hFF80, 16'hFF80, 16'hFF80};
        tbl[9]  = '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 16'h7E00, 16'h7FC1, 16'h3F80, 16'h7FC0};
        tbl[10] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 16'h7C00, 16'h3F80, 16'h3F80, 16'h4000};
        tbl[11] = '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 16'h3C00, 16'h3F80, 16'hBF80, 16'h0000};
        tbl[12] = '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 16'h1400, 16'h3F81, 16'h3F80, 16'h3C00};
        tbl[13] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 16'h7E00, 16'h7F80, 16'h7F80, 16'h7FC0};
        tbl[14] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000};
        tbl[15] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 16'hBC00, 16'hC000, 16'h3F80, 16'hBF80};
        tbl[16] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 16'h0000, 16'h0081, 16'h0080, 16'h0000};
        tbl[17] = '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 16'h3C00, 16'h3F7F, 16'h3B00, 16'h3F80};

        rst_b = 1'b0; de_in = 1'b0; op_sub = 1'b0;
        a = '0; b = '0; bfa = '0; bfb = '0;
        repeat (3) @(negedge clk);
        check("reset_de_out", {15'd0, de0}, 16'h0000);
        check("reset_data_out", q0, 16'h0000);
        check("reset_data_out_bf", q2, 16'h0000);
        rst_b = 1'b1;

        // isolated transaction: de_out must rise exactly five clocks later
        issue(16'h3C00, 16'h3C00, 1'b0, 16'h3F80, 16'h3F80, 16'h4000, 16'h4000, 16'h4000);
        idle();
        n = 1;
        while (!de0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("first_latency", 16'(n), 16'd5);
        drain();

        foreach (tbl[i])
            issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].bfa, tbl[i].bfb,
                  tbl[i].e0, tbl[i].e1, tbl[i].ebf);
        drain();
        repeat (3) idle();
        check("hold_fp16", q0, 16'h3C00);
        check("hold_bf16", q2, 16'h3F80);

        repeat (20) rand_issue();
        for (int k = 0; k < 10; k++) begin
            rand_issue();
            idle();
        end
        drain();

        // reset in the middle of a full pipe
        repeat (8) rand_issue();
        @(posedge clk);
        #2;
        check("pre_reset_de_out", {15'd0, de0}, 16'h0001);
        rst_b = 1'b0;
        #1;
        check("mid_reset_de_out", {13'd0, de0, de1, de2}, 16'h0000);
        check("mid_reset_data_out", q0, 16'h0000);
        q_fp.delete(); q_sat.delete(); q_bf.delete();
        repeat (2) @(negedge clk);
        idle();
        rst_b = 1'b1;
        repeat (8) idle();
        repeat (5) rand_issue();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
